video_chain_sequencer: RTL and testbench
========================================

Name: video_chain_sequencer

Overview:
- Per-frame configuration controller for the video effect routing mux.
- Latches the six raw source selects (already on the pixel clock) at each new_frame, then walks the chain from output back to base.
- Rejects routing loops and illegal codes, and commits a validated, glitch-free select set to the multi-mux once per frame.
- Reports which effect stages are in the active path and the total effect pipeline latency, used for GUI/overlay alignment.

Parameters:
- CRUSH_LATENCY, 2, pipeline depth of crush stage (cycles)
- DISTORTION_LATENCY, 3, pipeline depth of distortion stage
- FILTER_LATENCY, 6, pipeline depth of filter stage
- REVERB_LATENCY, 0, pipeline depth of reverb stage (currently a passthrough)
- LAT_WIDTH, 6, width of chain_latency

Ports:
- clk_pixel  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- new_frame  in  1  single-cycle frame-start pulse from the signal generator
- output_src_in, crush_src_in, distortion_src_in, filter_src_in, reverb_src_in, delay_src_in  in  3 each  raw selects (pixel clock domain)
- output_src, crush_src, distortion_src, filter_src, reverb_src, delay_src  out  3 each  committed selects to the mux
- stage_active  out  4  {reverb,filter,distortion,crush} in the active output path
- chain_latency  out  LAT_WIDTH  sum of active-stage latencies
- cfg_update  out  1  one-cycle pulse on every successful commit
- cfg_error  out  1  one-cycle pulse when a latched configuration is rejected
- error_count  out  8  saturating count of rejections

Behaviour:
- Source encoding (shared package): 0=BASE, 1=CRUSH, 2=DISTORTION, 3=FILTER, 4=REVERB; codes 5-7 are illegal.
- Reset values:
  - All committed selects = 0, so output is fed from base.
  - stage_active=0, chain_latency=0, cfg_update=0, cfg_error=0, error_count=0.
  - FSM returns to IDLE. A reset mid-walk discards the walk.
- FSM states: IDLE, WALK, COMMIT, REJECT.
- IDLE:
  - On new_frame, snapshot all six inputs into shadow registers.
  - Initialise cur=shadow output_src, visited=0, lat_acc=0, steps=0, then go to WALK.
- WALK (one hop per cycle):
  - cur==BASE -> COMMIT.
  - cur illegal (5-7) -> REJECT.
  - visited[cur] already set -> REJECT (loop).
  - Otherwise set visited[cur], add that stage's latency to lat_acc, set cur=shadow src of stage cur, and increment steps.
  - steps reaching 5 without hitting BASE -> REJECT. This is a guard only; the loop check makes it unreachable.
- Shadow delay_src check: it must be 0-4, else REJECT. It is not walked, because the delay path is frame-delayed and cannot loop combinationally.
- COMMIT (one cycle):
  - Copy the shadow output and delay selects to the outputs.
  - For each effect stage: if visited, copy its shadow select; else force its select to 0 so unused stages idle on base.
  - stage_active=visited, chain_latency=lat_acc, pulse cfg_update. Next state IDLE.
- REJECT (one cycle):
  - Pulse cfg_error; error_count += 1, saturating at 255.
  - Leave all committed outputs unchanged (previous frame's config is held). Next state IDLE.
- Latency and timing:
  - Commit or reject completes at most 7 cycles after new_frame.
  - Committed outputs change only in the COMMIT cycle, so they are stable for the rest of the frame.
- Arithmetic: lat_acc saturates at 2^LAT_WIDTH-1. With the defaults the maximum is 11, so saturation does not occur.
- new_frame while not in IDLE: ignored; the walk is neither restarted nor queued.
- Inputs changing during WALK: no effect, since only the shadow registers are used.
- The input snapshot includes the cycle in which new_frame is asserted.

Decomposition:
- Package video_chain_pkg holds:
  - typedef src_t (logic [2:0]) and the constants SRC_BASE, SRC_CRUSH, SRC_DISTORTION, SRC_FILTER, SRC_REVERB.
  - The FSM state enum.
  - Function is_legal_src.
  - Shared with the multi-mux.
- Sub-module: none required. The per-stage latency lookup is an in-module function.

Test Plan:
- Reset, then idle with no new_frame -> all selects 0, stage_active=0, chain_latency=0, no pulses.
- Set output=3, filter=2, distortion=1, crush=0, reverb=4; pulse new_frame.
  - Within 7 cycles: cfg_update pulse.
  - output_src=3, filter_src=2, distortion_src=1, crush_src=0, reverb_src=0 (forced).
  - stage_active=4'b0111, chain_latency=11.
- Loop: output=1, crush=2, distortion=1; new_frame.
  - cfg_error pulse, error_count=1, outputs equal the previous commit, no cfg_update.
- Illegal code: output=6, or delay_src=7 with a valid chain -> cfg_error, outputs held.
- Change inputs 2 cycles after new_frame, mid-walk -> commit reflects the snapshot values. A second new_frame during the walk is ignored, producing exactly one cfg_update.
- 256 consecutive rejected frames -> error_count saturates at 255.
- Assert rst during WALK -> outputs return to reset values and no pulse follows.

Source files
------------

// File: rtl/video_chain_pkg.sv
// Shared definitions for the video effect routing chain: source codes,
// sequencer FSM states and the source legality check. Also used by the multi-mux.
package video_chain_pkg;

    typedef logic [2:0] src_t;

    localparam src_t SRC_BASE       = 3'd0;
    localparam src_t SRC_CRUSH      = 3'd1;
    localparam src_t SRC_DISTORTION = 3'd2;
    localparam src_t SRC_FILTER     = 3'd3;
    localparam src_t SRC_REVERB     = 3'd4;

    // Hop count after which a walk is abandoned (loop detection fires first).
    localparam logic [2:0] MAX_STEPS = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WALK   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_REJECT = 2'd3
    } chain_state_t;

    // Codes above REVERB do not name any source.
    function automatic logic is_legal_src(input src_t s);
        return (s <= SRC_REVERB);
    endfunction

endpackage

// File: rtl/video_chain_sequencer.sv
// Per-frame routing sequencer: snapshots the raw selects on new_frame, walks
// the chain from the output back to base, and either commits a validated
// select set (with active-stage mask and total latency) or rejects it and
// holds the previous frame's configuration.
module video_chain_sequencer
    import video_chain_pkg::*;
#(
    parameter int CRUSH_LATENCY      = 2,
    parameter int DISTORTION_LATENCY = 3,
    parameter int FILTER_LATENCY     = 6,
    parameter int REVERB_LATENCY     = 0,
    parameter int LAT_WIDTH          = 6
) (
    input  logic                 clk_pixel,
    input  logic                 rst,
    input  logic                 new_frame,
    input  logic [2:0]           output_src_in,
    input  logic [2:0]           crush_src_in,
    input  logic [2:0]           distortion_src_in,
    input  logic [2:0]           filter_src_in,
    input  logic [2:0]           reverb_src_in,
    input  logic [2:0]           delay_src_in,
    output logic [2:0]           output_src,
    output logic [2:0]           crush_src,
    output logic [2:0]           distortion_src,
    output logic [2:0]           filter_src,
    output logic [2:0]           reverb_src,
    output logic [2:0]           delay_src,
    output logic [3:0]           stage_active,
    output logic [LAT_WIDTH-1:0] chain_latency,
    output logic                 cfg_update,
    output logic                 cfg_error,
    output logic [7:0]           error_count
);

    // Pipeline depth of each effect stage; base and illegal codes add nothing.
    function automatic logic [LAT_WIDTH-1:0] stage_latency(input src_t s);
        case (s)
            SRC_CRUSH:      stage_latency = LAT_WIDTH'(CRUSH_LATENCY);
            SRC_DISTORTION: stage_latency = LAT_WIDTH'(DISTORTION_LATENCY);
            SRC_FILTER:     stage_latency = LAT_WIDTH'(FILTER_LATENCY);
            SRC_REVERB:     stage_latency = LAT_WIDTH'(REVERB_LATENCY);
            default:        stage_latency = '0;
        endcase
    endfunction

    chain_state_t state_q, state_d;

    src_t sh_output_q, sh_output_d, sh_crush_q, sh_crush_d, sh_dist_q, sh_dist_d;
    src_t sh_filter_q, sh_filter_d, sh_reverb_q, sh_reverb_d, sh_delay_q, sh_delay_d;

    src_t                 cur_q, cur_d;
    logic [3:0]           visited_q, visited_d;
    logic [LAT_WIDTH-1:0] lat_acc_q, lat_acc_d;
    logic [2:0]           steps_q, steps_d;

    src_t output_src_q, output_src_d, crush_src_q, crush_src_d, dist_src_q, dist_src_d;
    src_t filter_src_q, filter_src_d, reverb_src_q, reverb_src_d, delay_src_q, delay_src_d;
    logic [3:0]           stage_active_q, stage_active_d;
    logic [LAT_WIDTH-1:0] chain_latency_q, chain_latency_d;
    logic                 cfg_update_q, cfg_update_d;
    logic                 cfg_error_q, cfg_error_d;
    logic [7:0]           error_count_q, error_count_d;

    // visited bit i corresponds to source code i+1 (crush..reverb)
    logic [1:0]         stage_idx_s;
    logic [LAT_WIDTH:0] hop_sum_s;
    src_t               next_src_s;

    assign stage_idx_s = 2'(cur_q - SRC_CRUSH);
    assign hop_sum_s   = {1'b0, lat_acc_q} + {1'b0, stage_latency(cur_q)};

    // Source feeding the stage currently being visited, taken from the snapshot.
    always_comb begin
        next_src_s = SRC_BASE;
        case (cur_q)
            SRC_CRUSH:      next_src_s = sh_crush_q;
            SRC_DISTORTION: next_src_s = sh_dist_q;
            SRC_FILTER:     next_src_s = sh_filter_q;
            SRC_REVERB:     next_src_s = sh_reverb_q;
            default:        next_src_s = SRC_BASE;
        endcase
    end

    // State and all datapath/output registers, synchronous reset.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sh_output_q     <= SRC_BASE;
            sh_crush_q      <= SRC_BASE;
            sh_dist_q       <= SRC_BASE;
            sh_filter_q     <= SRC_BASE;
            sh_reverb_q     <= SRC_BASE;
            sh_delay_q      <= SRC_BASE;
            cur_q           <= SRC_BASE;
            visited_q       <= 4'd0;
            lat_acc_q       <= '0;
            steps_q         <= 3'd0;
            output_src_q    <= SRC_BASE;
            crush_src_q     <= SRC_BASE;
            dist_src_q      <= SRC_BASE;
            filter_src_q    <= SRC_BASE;
            reverb_src_q    <= SRC_BASE;
            delay_src_q     <= SRC_BASE;
            stage_active_q  <= 4'd0;
            chain_latency_q <= '0;
            cfg_update_q    <= 1'b0;
            cfg_error_q     <= 1'b0;
            error_count_q   <= 8'd0;
        end else begin
            state_q         <= state_d;
            sh_output_q     <= sh_output_d;
            sh_crush_q      <= sh_crush_d;
            sh_dist_q       <= sh_dist_d;
            sh_filter_q     <= sh_filter_d;
            sh_reverb_q     <= sh_reverb_d;
            sh_delay_q      <= sh_delay_d;
            cur_q           <= cur_d;
            visited_q       <= visited_d;
            lat_acc_q       <= lat_acc_d;
            steps_q         <= steps_d;
            output_src_q    <= output_src_d;
            crush_src_q     <= crush_src_d;
            dist_src_q      <= dist_src_d;
            filter_src_q    <= filter_src_d;
            reverb_src_q    <= reverb_src_d;
            delay_src_q     <= delay_src_d;
            stage_active_q  <= stage_active_d;
            chain_latency_q <= chain_latency_d;
            cfg_update_q    <= cfg_update_d;
            cfg_error_q     <= cfg_error_d;
            error_count_q   <= error_count_d;
        end
    end

    // Next-state: one hop per WALK cycle until base, a bad code, or a loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (new_frame) state_d = ST_WALK;
                else           state_d = ST_IDLE;
            end
            ST_WALK: begin
                if (!is_legal_src(sh_delay_q))      state_d = ST_REJECT;
                else if (cur_q == SRC_BASE)         state_d = ST_COMMIT;
                else if (!is_legal_src(cur_q))      state_d = ST_REJECT;
                else if (visited_q[stage_idx_s])    state_d = ST_REJECT;
                else if (steps_q >= MAX_STEPS)      state_d = ST_REJECT;
                else                                state_d = ST_WALK;
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_REJECT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Snapshot, walk bookkeeping, and commit/reject updates of the outputs.
    always_comb begin
        sh_output_d     = sh_output_q;
        sh_crush_d      = sh_crush_q;
        sh_dist_d       = sh_dist_q;
        sh_filter_d     = sh_filter_q;
        sh_reverb_d     = sh_reverb_q;
        sh_delay_d      = sh_delay_q;
        cur_d           = cur_q;
        visited_d       = visited_q;
        lat_acc_d       = lat_acc_q;
        steps_d         = steps_q;
        output_src_d    = output_src_q;
        crush_src_d     = crush_src_q;
        dist_src_d      = dist_src_q;
        filter_src_d    = filter_src_q;
        reverb_src_d    = reverb_src_q;
        delay_src_d     = delay_src_q;
        stage_active_d  = stage_active_q;
        chain_latency_d = chain_latency_q;
        cfg_update_d    = 1'b0;
        cfg_error_d     = 1'b0;
        error_count_d   = error_count_q;
        case (state_q)
            ST_IDLE: begin
                if (new_frame) begin
                    sh_output_d = output_src_in;
                    sh_crush_d  = crush_src_in;
                    sh_dist_d   = distortion_src_in;
                    sh_filter_d = filter_src_in;
                    sh_reverb_d = reverb_src_in;
                    sh_delay_d  = delay_src_in;
                    cur_d       = output_src_in;
                    visited_d   = 4'd0;
                    lat_acc_d   = '0;
                    steps_d     = 3'd0;
                end else begin
                    cur_d = cur_q;
                end
            end
            ST_WALK: begin
                if (state_d == ST_WALK) begin
                    visited_d[stage_idx_s] = 1'b1;
                    lat_acc_d = hop_sum_s[LAT_WIDTH] ? '1 : hop_sum_s[LAT_WIDTH-1:0];
                    cur_d     = next_src_s;
                    steps_d   = steps_q + 3'd1;
                end else begin
                    cur_d = cur_q;
                end
            end
            ST_COMMIT: begin
                // Unused stages are parked on base so they never see stale routing.
                output_src_d    = sh_output_q;
                delay_src_d     = sh_delay_q;
                crush_src_d     = visited_q[0] ? sh_crush_q  : SRC_BASE;
                dist_src_d      = visited_q[1] ? sh_dist_q   : SRC_BASE;
                filter_src_d    = visited_q[2] ? sh_filter_q : SRC_BASE;
                reverb_src_d    = visited_q[3] ? sh_reverb_q : SRC_BASE;
                stage_active_d  = visited_q;
                chain_latency_d = lat_acc_q;
                cfg_update_d    = 1'b1;
            end
            ST_REJECT: begin
                cfg_error_d = 1'b1;
                if (error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
                else                        error_count_d = error_count_q;
            end
            default: begin
                cfg_update_d = 1'b0;
            end
        endcase
    end

    assign output_src     = output_src_q;
    assign crush_src      = crush_src_q;
    assign distortion_src = dist_src_q;
    assign filter_src     = filter_src_q;
    assign reverb_src     = reverb_src_q;
    assign delay_src      = delay_src_q;
    assign stage_active   = stage_active_q;
    assign chain_latency  = chain_latency_q;
    assign cfg_update     = cfg_update_q;
    assign cfg_error      = cfg_error_q;
    assign error_count    = error_count_q;

endmodule

// File: tb/tb_video_chain_sequencer.sv
// Self-checking bench for video_chain_sequencer: directed scenarios plus
// randomized frames, compared against a chain-walk reference model.
module tb_video_chain_sequencer;

    logic       clk_pixel = 1'b0;
    logic       rst = 1'b1;
    logic       new_frame = 1'b0;
    logic [2:0] output_src_in = 3'd0, crush_src_in = 3'd0, distortion_src_in = 3'd0;
    logic [2:0] filter_src_in = 3'd0, reverb_src_in = 3'd0, delay_src_in = 3'd0;
    logic [2:0] output_src, crush_src, distortion_src, filter_src, reverb_src, delay_src;
    logic [3:0] stage_active;
    logic [5:0] chain_latency;
    logic       cfg_update, cfg_error;
    logic [7:0] error_count;

    always #5 clk_pixel = ~clk_pixel;

    video_chain_sequencer dut (
        .clk_pixel         (clk_pixel),
        .rst               (rst),
        .new_frame         (new_frame),
        .output_src_in     (output_src_in),
        .crush_src_in      (crush_src_in),
        .distortion_src_in (distortion_src_in),
        .filter_src_in     (filter_src_in),
        .reverb_src_in     (reverb_src_in),
        .delay_src_in      (delay_src_in),
        .output_src        (output_src),
        .crush_src         (crush_src),
        .distortion_src    (distortion_src),
        .filter_src        (filter_src),
        .reverb_src        (reverb_src),
        .delay_src         (delay_src),
        .stage_active      (stage_active),
        .chain_latency     (chain_latency),
        .cfg_update        (cfg_update),
        .cfg_error         (cfg_error),
        .error_count       (error_count)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model of what the mux should currently be configured with.
    int m_out = 0, m_cr = 0, m_di = 0, m_fi = 0, m_re = 0, m_de = 0;
    int m_act = 0, m_lat = 0, m_err = 0;
    int lat_tab [5] = '{0, 2, 3, 6, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".output_src"},     32'(output_src),     32'(m_out));
        chk({tag, ".crush_src"},      32'(crush_src),      32'(m_cr));
        chk({tag, ".distortion_src"}, 32'(distortion_src), 32'(m_di));
        chk({tag, ".filter_src"},     32'(filter_src),     32'(m_fi));
        chk({tag, ".reverb_src"},     32'(reverb_src),     32'(m_re));
        chk({tag, ".delay_src"},      32'(delay_src),      32'(m_de));
        chk({tag, ".stage_active"},   32'(stage_active),   32'(m_act));
        chk({tag, ".chain_latency"},  32'(chain_latency),  32'(m_lat));
        chk({tag, ".error_count"},    32'(error_count),    32'(m_err));
    endtask

    function automatic logic [2:0] rand_code(input int illegal_pct);
        if (int'($urandom_range(0, 99)) < illegal_pct) return 3'(5 + $urandom_range(0, 2));
        return 3'($urandom_range(0, 4));
    endfunction

    // One frame: present config, pulse new_frame, watch 12 cycles, update model, check.
    task automatic run_frame(input string tag, input int o, input int c, input int d,
                             input int f, input int r, input int dl, input bit disturb);
        int  nxt [5];
        bit  ok;
        logic [3:0] vis;
        int  lat, cur, n_upd, n_err, first;
        nxt[0] = 0; nxt[1] = c; nxt[2] = d; nxt[3] = f; nxt[4] = r;
        ok = (dl <= 4); vis = 4'd0; lat = 0; cur = o;
        if (ok) begin
            for (int h = 0; h < 8; h++) begin
                if (cur == 0) break;
                if (cur > 4) begin ok = 1'b0; break; end
                if (vis[cur-1]) begin ok = 1'b0; break; end
                vis[cur-1] = 1'b1;
                lat += lat_tab[cur];
                cur = nxt[cur];
            end
        end

        @(negedge clk_pixel);
        output_src_in = 3'(o); crush_src_in = 3'(c); distortion_src_in = 3'(d);
        filter_src_in = 3'(f); reverb_src_in = 3'(r); delay_src_in = 3'(dl);
        new_frame = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        n_upd = 0; n_err = 0; first = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cfg_update === 1'b1) begin n_upd++; if (first == 0) first = cyc; end
            if (cfg_error === 1'b1)  begin n_err++; if (first == 0) first = cyc; end
            if (disturb && cyc == 2) begin
                output_src_in = rand_code(20); crush_src_in = rand_code(20);
                distortion_src_in = rand_code(20); filter_src_in = rand_code(20);
                reverb_src_in = rand_code(20); delay_src_in = rand_code(20);
                new_frame = 1'b1;
            end else if (disturb && cyc == 3) begin
                new_frame = 1'b0;
            end
            @(negedge clk_pixel);
        end

        if (ok) begin
            m_out = o; m_de = dl;
            m_cr = vis[0] ? c : 0; m_di = vis[1] ? d : 0;
            m_fi = vis[2] ? f : 0; m_re = vis[3] ? r : 0;
            m_act = int'(vis); m_lat = lat;
        end else begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        chk({tag, ".update_pulses"}, 32'(n_upd), ok ? 32'd1 : 32'd0);
        chk({tag, ".error_pulses"},  32'(n_err), ok ? 32'd0 : 32'd1);
        chk({tag, ".within_7"}, (first >= 1 && first <= 7) ? 32'd1 : 32'd0, 32'd1);
        check_outputs(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        // Reset and idle with no frames.
        repeat (3) @(negedge clk_pixel);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_pixel);
            if (cfg_update === 1'b1 || cfg_error === 1'b1) pulses++;
        end
        chk("idle.pulses", 32'(pulses), 32'd0);
        check_outputs("reset");

        // Full-length valid chain: output<-filter<-distortion<-crush<-base, reverb forced.
        run_frame("chain", 3, 0, 1, 2, 4, 0, 1'b0);
        chk("chain.latency11", 32'(chain_latency), 32'd11);
        chk("chain.active",    32'(stage_active),  32'b0111);
        // Loop crush<->distortion.
        run_frame("loop", 1, 2, 1, 0, 0, 0, 1'b0);
        chk("loop.errcnt1", 32'(error_count), 32'd1);
        // Illegal output code, then illegal delay with a valid chain.
        run_frame("ill_out", 6, 0, 0, 0, 0, 0, 1'b0);
        run_frame("ill_delay", 4, 0, 0, 0, 1, 7, 1'b0);
        // Inputs changed and a second new_frame mid-walk.
        run_frame("midwalk", 3, 0, 1, 2, 0, 2, 1'b1);
        run_frame("shortchain", 0, 3, 3, 3, 3, 4, 1'b1);

        // Randomized frames.
        for (int i = 0; i < 60; i++) begin
            run_frame("rand", int'(rand_code(10)), int'(rand_code(10)), int'(rand_code(10)),
                      int'(rand_code(10)), int'(rand_code(10)), int'(rand_code(5)),
                      ($urandom_range(0, 3) == 0));
        end

        // Saturate the rejection counter.
        for (int i = 0; i < 256; i++) run_frame("sat", 7, 0, 0, 0, 0, 0, 1'b0);
        chk("sat.errcnt255", 32'(error_count), 32'd255);

        // Reset in the middle of a walk: no pulse afterwards, reset values restored.
        @(negedge clk_pixel);
        output_src_in = 3'd3; filter_src_in = 3'd2; distortion_src_in = 3'd1;
        crush_src_in = 3'd0; reverb_src_in = 3'd0; delay_src_in = 3'd0;
        new_frame = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        @(negedge clk_pixel);
        rst = 1'b1;
        @(negedge clk_pixel);
        rst = 1'b0;
        m_out = 0; m_cr = 0; m_di = 0; m_fi = 0; m_re = 0; m_de = 0;
        m_act = 0; m_lat = 0; m_err = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (cfg_update === 1'b1 || cfg_error === 1'b1) pulses++;
            @(negedge clk_pixel);
        end
        chk("rstwalk.pulses", 32'(pulses), 32'd0);
        check_outputs("rstwalk");

        // Sequencer works normally after the mid-walk reset.
        run_frame("post_rst", 2, 0, 1, 0, 0, 3, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
